// File: rtl/sound_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : sound_multichannel
// Description : Multi-channel square-wave tone generator. Each channel holds a
//               half-period, a cycle counter, a toggle flop and (optionally) a
//               remaining-duration register counted in prescaler ticks.
//               Channel square waves are ORed onto a buzzer pin and counted
//               onto a small audio level bus.
//
// Configuration macro:
//   SOUND_DURATION_EN  defined   -> shared tick prescaler, per-channel
//                                   remaining-duration counters and ch_done
//                                   pulses are built.
//                      undefined -> wr_duration is ignored, notes play until
//                                   rewritten, ch_done is tied to 0.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_async_n     in   asynchronous active-low reset (release synchronised)
//   wr_en           in   single-cycle write strobe
//   wr_channel      in   channel addressed by wr_en (out-of-range ignored)
//   wr_half_period  in   clk cycles per half-wave, 0 silences the channel
//   wr_duration     in   note length in ticks, 0 plays until rewritten
//   ch_active       out  per channel: a non-silent note is loaded
//   ch_done         out  per channel: one-cycle pulse when a note expires
//   audio_level     out  number of channel square waves currently high
//   buzzer          out  OR of all channel square waves
//
// Revision    : 1.0  initial release
// ============================================================================
module sound_multichannel #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 26,
    parameter int DUR_WIDTH    = 16,
    parameter int TICK_DIV     = 50000
) (
    input  logic                                                    clk,
    input  logic                                                    rst_async_n,
    input  logic                                                    wr_en,
    input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] wr_channel,
    input  logic [COUNT_WIDTH-1:0]                                  wr_half_period,
    input  logic [DUR_WIDTH-1:0]                                    wr_duration,
    output logic [NUM_CHANNELS-1:0]                                 ch_active,
    output logic [NUM_CHANNELS-1:0]                                 ch_done,
    output logic [$clog2(NUM_CHANNELS+1)-1:0]                       audio_level,
    output logic                                                    buzzer
);

    localparam int c_CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_LVL_W = $clog2(NUM_CHANNELS + 1);

    // One extra bit so that NUM_CHANNELS itself is representable when it is
    // an exact power of two (e.g. 8 channels with a 3-bit address).
    localparam logic [c_CH_W:0]        c_NUM_CH  = (c_CH_W + 1)'(NUM_CHANNELS);
    localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE = COUNT_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Reset synchroniser: assertion clears everything at once, release reaches
    // the channel logic only after two clk edges.
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // Write decode: addresses at or above NUM_CHANNELS touch nothing.
    // ------------------------------------------------------------------------
    logic w_wr_ok;

    assign w_wr_ok = wr_en && ({1'b0, wr_channel} < c_NUM_CH);

`ifdef SOUND_DURATION_EN
    // ------------------------------------------------------------------------
    // Free-running duration prescaler, shared by every channel. Writes never
    // restart it, so a note's first tick can arrive anywhere in the period.
    // ------------------------------------------------------------------------
    localparam int                   c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0]   c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [DUR_WIDTH-1:0] c_DUR_ONE  = DUR_WIDTH'(1);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;

    assign w_tick = (r_pre == c_PRE_LAST);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end
`else
    // Duration input and tick divider have no function in this build.
    logic w_unused_cfg;

    assign w_unused_cfg = ^{wr_duration, (TICK_DIV != 0)};
`endif

    // ------------------------------------------------------------------------
    // Tone channels
    // ------------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] w_tog;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(gi);

            logic [COUNT_WIDTH-1:0] r_half;
            logic [COUNT_WIDTH-1:0] r_cnt;
            logic                   r_tog;
            logic                   r_act;
            logic                   w_wr;
            logic                   w_wrap;
            logic                   w_expire;

            assign w_wr   = w_wr_ok && (wr_channel == c_IDX);
            // Counter runs 0..half-1; wrapping toggles the wave, so the first
            // rising edge lands exactly half_period edges after the write.
            assign w_wrap = (r_cnt == (r_half - c_CNT_ONE));

`ifdef SOUND_DURATION_EN
            logic [DUR_WIDTH-1:0] r_rem;
            logic                 r_done;

            // Last tick of a finite note. A remaining value of 0 never
            // matches, which is what makes duration 0 an endless note.
            assign w_expire = w_tick && (r_rem == c_DUR_ONE);

            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_rem  <= '0;
                    r_done <= 1'b0;
                end else begin
                    r_done <= 1'b0;
                    if (w_wr) begin
                        // A write on the expiry edge replaces the note and
                        // suppresses the done pulse.
                        r_rem <= wr_duration;
                    end else if (r_act && w_tick) begin
                        if (r_rem == c_DUR_ONE) begin
                            r_rem  <= '0;
                            r_done <= 1'b1;
                        end else if (r_rem > c_DUR_ONE) begin
                            r_rem <= r_rem - c_DUR_ONE;
                        end
                    end
                end
            end

            assign ch_done[gi] = r_done;
`else
            assign w_expire    = 1'b0;
            assign ch_done[gi] = 1'b0;
`endif

            always_ff @(posedge clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_half <= '0;
                    r_cnt  <= '0;
                    r_tog  <= 1'b0;
                    r_act  <= 1'b0;
                end else if (w_wr) begin
                    r_half <= wr_half_period;
                    r_cnt  <= '0;
                    r_tog  <= 1'b0;
                    r_act  <= (wr_half_period != '0);
                end else if (r_act) begin
                    if (w_expire) begin
                        r_half <= '0;
                        r_cnt  <= '0;
                        r_tog  <= 1'b0;
                        r_act  <= 1'b0;
                    end else if (w_wrap) begin
                        r_cnt <= '0;
                        r_tog <= ~r_tog;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end

            assign w_tog[gi]     = r_tog;
            assign ch_active[gi] = r_act;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Mixing: driven from toggle flops only, so input activity cannot glitch
    // the buzzer pin.
    // ------------------------------------------------------------------------
    logic [c_LVL_W-1:0] w_level;

    always_comb begin
        w_level = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            w_level = w_level + c_LVL_W'(w_tog[k]);
        end
    end

    assign audio_level = w_level;
    assign buzzer      = |w_tog;

endmodule
`default_nettype wire

// File: tb/tb_sound_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_multichannel
// Description : Scoreboard bench for sound_multichannel. Stimulus schedules
//               writes on numbered clock edges and queues the outputs expected
//               after those edges; a monitor compares them at each falling
//               edge. Five channels are used so that a 3-bit address can name
//               channels that do not exist. Duration checks follow whichever
//               way SOUND_DURATION_EN is set for the build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sound_multichannel;

    localparam int NCH = 5;
    localparam int CW  = 26;
    localparam int DW  = 16;
    localparam int TD  = 10;
    localparam int AW  = 3;
    localparam int LW  = 3;

    localparam int K_ACT  = 0;
    localparam int K_DONE = 1;
    localparam int K_LVL  = 2;
    localparam int K_BUZ  = 3;

    logic          clk = 1'b0;
    logic          rst_async_n;
    logic          wr_en;
    logic [AW-1:0] wr_channel;
    logic [CW-1:0] wr_half_period;
    logic [DW-1:0] wr_duration;
    logic [NCH-1:0] ch_active;
    logic [NCH-1:0] ch_done;
    logic [LW-1:0] audio_level;
    logic          buzzer;

    sound_multichannel #(
        .NUM_CHANNELS (NCH),
        .COUNT_WIDTH  (CW),
        .DUR_WIDTH    (DW),
        .TICK_DIV     (TD)
    ) dut (
        .clk            (clk),
        .rst_async_n    (rst_async_n),
        .wr_en          (wr_en),
        .wr_channel     (wr_channel),
        .wr_half_period (wr_half_period),
        .wr_duration    (wr_duration),
        .ch_active      (ch_active),
        .ch_done        (ch_done),
        .audio_level    (audio_level),
        .buzzer         (buzzer)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable when read on a falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int k;
        int v;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   last  = 0;
    int   p2    = 0;

    function automatic string knm(input int k);
        case (k)
            K_ACT:   return "ch_active";
            K_DONE:  return "ch_done";
            K_LVL:   return "audio_level";
            default: return "buzzer";
        endcase
    endfunction

    function automatic void chk(input string nm, input int c,
                                input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s after edge %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endfunction

    // Keep the queue sorted by cycle so the monitor only looks at the front.
    function automatic void push(input int c, input int k, input int v);
        exp_t e;
        int   idx;
        e.c = c;
        e.k = k;
        e.v = v;
        idx = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].c > c) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
        if (c > last) last = c;
    endfunction

    function automatic void push4(input int c, input int act, input int done,
                                  input int lvl, input int buz);
        push(c, K_ACT, act);
        push(c, K_DONE, done);
        push(c, K_LVL, lvl);
        push(c, K_BUZ, buz);
    endfunction

    // Square wave level dt edges after a write of half period h.
    function automatic int wave(input int h, input int dt);
        if (dt < 0) return 0;
        return (dt / h) % 2;
    endfunction

    // First prescaler tick edge strictly after edge e. Logic leaves reset
    // after edge p2 and the prescaler then wraps every TD edges.
    function automatic int tick_after(input int e);
        return p2 + ((e - p2) / TD + 1) * TD;
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] a;
        while (q.size() != 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            case (e.k)
                K_ACT:   a = 32'(ch_active);
                K_DONE:  a = 32'(ch_done);
                K_LVL:   a = 32'(audio_level);
                default: a = 32'(buzzer);
            endcase
            if (e.c < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL %s for edge %0d checked late at %0d, expected %0h",
                         knm(e.k), e.c, cyc, e.v);
            end else begin
                chk(knm(e.k), e.c, a, 32'(e.v));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Present a write so that it is captured on rising edge number e.
    task automatic wr_at(input int e, input int ch, input int h, input int d);
        wait_cyc(e - 1);
        if (cyc != e - 1) begin
            n_chk++;
            n_err++;
            $display("FAIL schedule: write for edge %0d issued at %0d", e, cyc);
        end
        wr_en          = 1'b1;
        wr_channel     = AW'(ch);
        wr_half_period = CW'(h);
        wr_duration    = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w, w2, wa, wb, wc, wd, we, wf, e, ef, l, a2;

        rst_async_n    = 1'b0;
        wr_en          = 1'b0;
        wr_channel     = '0;
        wr_half_period = '0;
        wr_duration    = '0;

        // Outputs idle while reset is held.
        for (int c = 1; c <= 3; c++) push4(c, 0, 0, 0, 0);
        wait_cyc(4);
        rst_async_n = 1'b1;
        p2 = cyc + 2;

        // Single tone, half period 4: first rise 4 edges after the write.
        w = last + 4;
        for (int c = cyc + 1; c < w; c++) push4(c, 0, 0, 0, 0);
        for (int c = w; c <= w + 16; c++) push4(c, 1, 0, wave(4, c - w), wave(4, c - w));
        w2 = w + 17;
        for (int c = w2; c <= w2 + 2; c++) push4(c, 0, 0, 0, 0);
        wr_at(w, 0, 4, 0);
        wr_at(w2, 0, 0, 0);

        // Two and then three channels mixed; channel 4 at half period 1.
        wa = last + 3;
        wb = wa + 1;
        wc = wb + 13;
        for (int c = wb; c < wc; c++) begin
            l = wave(2, c - wa) + wave(3, c - wb);
            push4(c, 'h03, 0, l, int'(l != 0));
        end
        for (int c = wc; c <= wc + 6; c++) begin
            l = wave(2, c - wa) + wave(3, c - wb) + wave(1, c - wc);
            push4(c, 'h13, 0, l, int'(l != 0));
        end
        for (int c = wc + 10; c <= wc + 11; c++) push4(c, 0, 0, 0, 0);
        wr_at(wa, 0, 2, 0);
        wr_at(wb, 1, 3, 0);
        wr_at(wc, 4, 1, 0);
        wr_at(wc + 7, 0, 0, 0);
        wr_at(wc + 8, 1, 0, 0);
        wr_at(wc + 9, 4, 0, 0);

        // Writes to channels 5..7 must leave the running channel 0 untouched.
        wd = last + 3;
        for (int c = wd; c <= wd + 14; c++) push4(c, 1, 0, wave(4, c - wd), wave(4, c - wd));
        wr_at(wd, 0, 4, 0);
        wr_at(wd + 2, 7, 1, 0);
        wr_at(wd + 3, 5, 2, 5);
        wr_at(wd + 4, 6, 3, 0);

`ifdef SOUND_DURATION_EN
        // Three-tick note on channel 2 expires on the third tick edge.
        we = last + 3;
        e  = tick_after(tick_after(tick_after(we)));
        for (int c = we; c <= e + 2; c++) begin
            a2 = int'(c < e);
            l  = wave(4, c - wd) + (a2 != 0 ? wave(3, c - we) : 0);
            push4(c, (a2 != 0) ? 'h05 : 'h01, (c == e) ? 'h04 : 0, l, int'(l != 0));
        end
        wr_at(we, 2, 3, 3);

        // Rewriting on the expiry edge keeps the channel alive, no done pulse.
        wf = last + 3;
        ef = tick_after(tick_after(tick_after(wf)));
        for (int c = wf; c <= ef + 12; c++) begin
            l = wave(4, c - wd) + ((c < ef) ? wave(3, c - wf) : wave(5, c - ef));
            push4(c, 'h05, 0, l, int'(l != 0));
        end
        wr_at(wf, 2, 3, 3);
        wr_at(ef, 2, 5, 0);
`else
        // Duration ignored: a one-tick note keeps playing.
        we = last + 3;
        for (int c = we; c <= we + 35; c++) begin
            l = wave(4, c - wd) + wave(3, c - we);
            push4(c, 'h05, 0, l, int'(l != 0));
        end
        wr_at(we, 2, 3, 1);
`endif

        // Asynchronous reset in the middle of two running notes.
        wait_cyc(last);
        #1;
        chk("pre_reset ch_active", cyc, 32'(ch_active), 32'h05);
        rst_async_n = 1'b0;
        #1;
        chk("async ch_active", cyc, 32'(ch_active), 32'h0);
        chk("async audio_level", cyc, 32'(audio_level), 32'h0);
        chk("async buzzer", cyc, 32'(buzzer), 32'h0);
        chk("async ch_done", cyc, 32'(ch_done), 32'h0);
        for (int c = cyc + 1; c <= cyc + 3; c++) push4(c, 0, 0, 0, 0);
        wait_cyc(cyc + 3);
        rst_async_n = 1'b1;

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s for edge %0d never checked", knm(q[0].k), q[0].c);
            void'(q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
